// File: rtl/radix_converter_seq.sv
// Sequential binary-to-radix converter (radix 2..16) built on one iterative
// restoring divider. Digits are packed one nibble each, LSD in the low nibble.
module radix_converter_seq #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned NDIG  = 6,
    parameter int unsigned CW    = $clog2(NDIG + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [WIDTH-1:0]      din,
    input  logic [4:0]            radix,
    output logic                  busy,
    output logic                  done,
    output logic [4*NDIG-1:0]     digits,
    output logic [CW-1:0]         ndigits,
    output logic                  ovf,
    output logic                  err
);

    localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned DW = 4 * NDIG;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_DIV   = 2'd1,
        S_STORE = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [4:0]        rem_q, rem_d;
    logic [BW-1:0]     bit_q, bit_d;
    logic [4:0]        rad_q, rad_d;
    logic [DW-1:0]     digits_q, digits_d;
    logic [CW-1:0]     ndig_q, ndig_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    // Trial subtraction for one restoring-division step; 6 bits so the shifted
    // remainder can never wrap before the compare.
    logic [5:0]        trial_c;
    logic              ge_c;
    logic              radix_ok_c;

    assign trial_c    = {1'b0, rem_q[3:0], quo_q[WIDTH-1]};
    assign ge_c       = (trial_c >= {1'b0, rad_q});
    assign radix_ok_c = (radix >= 5'd2) && (radix <= 5'd16);

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            quo_q    <= '0;
            rem_q    <= '0;
            bit_q    <= '0;
            rad_q    <= '0;
            digits_q <= '0;
            ndig_q   <= '0;
            ovf_q    <= 1'b0;
            err_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            quo_q    <= quo_d;
            rem_q    <= rem_d;
            bit_q    <= bit_d;
            rad_q    <= rad_d;
            digits_q <= digits_d;
            ndig_q   <= ndig_d;
            ovf_q    <= ovf_d;
            err_q    <= err_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Next-state, divider step, digit store and registered status outputs.
    always_comb begin
        state_d  = state_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        bit_d    = bit_q;
        rad_d    = rad_q;
        digits_d = digits_q;
        ndig_d   = ndig_q;
        ovf_d    = ovf_q;
        err_d    = err_q;
        busy_d   = busy_q;
        done_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    rad_d    = radix;
                    digits_d = '0;
                    ndig_d   = '0;
                    ovf_d    = 1'b0;
                    if (radix_ok_c) begin
                        err_d   = 1'b0;
                        quo_d   = din;
                        rem_d   = '0;
                        bit_d   = BW'(WIDTH - 1);
                        busy_d  = 1'b1;
                        state_d = S_DIV;
                    end else begin
                        // Bad radix: report immediately, no division.
                        err_d   = 1'b1;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        state_d = S_FIN;
                    end
                end
            end

            S_DIV: begin
                // Dividend bits shift out the top while quotient bits shift in.
                if (ge_c) begin
                    rem_d = 5'(trial_c - {1'b0, rad_q});
                    quo_d = {quo_q[WIDTH-2:0], 1'b1};
                end else begin
                    rem_d = trial_c[4:0];
                    quo_d = {quo_q[WIDTH-2:0], 1'b0};
                end
                if (bit_q == '0) begin
                    state_d = S_STORE;
                end else begin
                    bit_d = bit_q - BW'(1);
                end
            end

            S_STORE: begin
                for (int unsigned k = 0; k < NDIG; k++) begin
                    if (ndig_q == CW'(k)) begin
                        digits_d[4*k +: 4] = rem_q[3:0];
                    end
                end
                ndig_d = ndig_q + CW'(1);
                rem_d  = '0;
                bit_d  = BW'(WIDTH - 1);
                if (quo_q == '0) begin
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else if (ndig_d == CW'(NDIG)) begin
                    ovf_d   = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_FIN;
                end else begin
                    state_d = S_DIV;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    assign busy    = busy_q;
    assign done    = done_q;
    assign digits  = digits_q;
    assign ndigits = ndig_q;
    assign ovf     = ovf_q;
    assign err     = err_q;

endmodule
